// File: rtl/cake_order_gen_pkg.sv
// Shared constants, state encoding and cake helper for the cake sequence generator.
package bitbakery_pkg;

    localparam int          CAKE_W    = 3;
    localparam int          NUM_CAKES = 7;
    localparam int          LFSR_W    = 8;
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    localparam logic [0:0]  STATE_IDLE   = 1'b0;
    localparam logic [0:0]  STATE_REPLAY = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = STATE_IDLE,
        ST_REPLAY = STATE_REPLAY
    } state_t;

    // Successor cake index, wrapping 6 -> 0.
    function automatic logic [CAKE_W-1:0] next_cake(input logic [CAKE_W-1:0] c);
        return (c >= CAKE_W'(NUM_CAKES - 1)) ? '0 : c + CAKE_W'(1);
    endfunction

endpackage

// File: rtl/cake_order_gen_if.sv
// Address stream from the sequence generator to the cake ROM (valid/ready with last marker).
interface cake_order_gen_if;
    import bitbakery_pkg::*;

    logic [CAKE_W-1:0] address;
    logic              addr_valid;
    logic              last;
    logic              addr_ready;

    modport master (output address, output addr_valid, output last, input addr_ready);
    modport slave  (input address, input addr_valid, input last, output addr_ready);

endinterface

// File: rtl/cake_order_gen_lfsr.sv
// Free-running 8-bit Fibonacci LFSR and its mapping onto a cake index 0..6.
module cake_lfsr
    import bitbakery_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] lfsr,
    output logic [CAKE_W-1:0] cake
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lfsr <= seed;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    // Value 7 is not a cake: fall back to the next field, then to cake 0.
    always_comb begin
        if (lfsr[2:0] != 3'd7) begin
            cake = lfsr[2:0];
        end else if (lfsr[5:3] != 3'd7) begin
            cake = lfsr[5:3];
        end else begin
            cake = '0;
        end
    end

endmodule

// File: rtl/cake_order.sv
// Cake memory-game sequence generator: grows a random cake sequence and replays it as ROM addresses.
// Optional build macro CAKE_ORDER_NO_REPEAT_EN forbids two equal consecutive entries.
module cake_order_gen
    import bitbakery_pkg::*;
#(
    parameter int         SEQ_DEPTH = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           new_round,
    input  logic                           replay,
    input  logic                           clear,
    cake_order_gen_if.master               bus,
    output logic [$clog2(SEQ_DEPTH+1)-1:0] seq_len,
    output logic                           full,
    output logic                           busy
);

    localparam int LEN_W = $clog2(SEQ_DEPTH + 1);
    localparam int IDX_W = $clog2(SEQ_DEPTH);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [CAKE_W-1:0] mem [SEQ_DEPTH];
    logic [LFSR_W-1:0] lfsr;
    logic [CAKE_W-1:0] cake;
    logic [CAKE_W-1:0] wr_cake;
    logic              at_last;
    logic              beat;
    logic              do_append;
    logic              do_start;

    cake_lfsr u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .lfsr    (lfsr),
        .cake    (cake)
    );

    // An all-zero LFSR would lock up and freeze the cake stream.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (lfsr != '0);
        end
    end

`ifdef CAKE_ORDER_NO_REPEAT_EN
    logic [CAKE_W-1:0] prev_cake;
    assign prev_cake = mem[IDX_W'(seq_len - LEN_W'(1))];
    assign wr_cake   = (seq_len != '0 && cake == prev_cake) ? next_cake(cake) : cake;
`else
    assign wr_cake   = cake;
`endif

    assign full    = (seq_len == LEN_W'(SEQ_DEPTH));
    assign at_last = (LEN_W'(idx) == seq_len - LEN_W'(1));
    assign beat    = bus.addr_valid & bus.addr_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear outranks new_round, which outranks replay.
    always_comb begin
        state_nxt = state;
        do_append = 1'b0;
        do_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt = ST_IDLE;
                end else if (new_round) begin
                    if (!full) begin
                        do_append = 1'b1;
                        state_nxt = ST_REPLAY;
                    end
                end else if (replay && seq_len != '0) begin
                    do_start  = 1'b1;
                    state_nxt = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                if (clear || (beat && at_last)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.addr_valid = 1'b0;
        bus.address    = '0;
        bus.last       = 1'b0;
        busy           = 1'b0;
        if (state == ST_REPLAY) begin
            bus.addr_valid = 1'b1;
            bus.address    = mem[idx];
            bus.last       = at_last;
            busy           = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            seq_len <= '0;
            idx     <= '0;
        end else if (clear) begin
            seq_len <= '0;
            idx     <= '0;
        end else begin
            if (do_append) begin
                seq_len <= seq_len + LEN_W'(1);
            end
            if (do_append || do_start) begin
                idx <= '0;
            end else if (state == ST_REPLAY && beat && !at_last) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Storage is not reset; seq_len alone defines which entries are meaningful.
    always_ff @(posedge clock) begin
        if (reset_n && do_append) begin
            mem[seq_len[IDX_W-1:0]] <= wr_cake;
        end
    end

endmodule
